// File: rtl/csidh_rr_pkg.sv
// csidh_rr_pkg: shared constants and the output beat bundle for the
// reduced-radix (2^57) to full-radix (2^64) limb converter.
package csidh_rr_pkg;

  localparam int LIMB_BITS  = 57;
  localparam int NLIMBS     = 9;
  localparam int NWORDS     = 8;
  localparam int CARRY_BITS = 7;
  localparam int BUF_BITS   = 120;
  localparam int WORD_BITS  = 64;
  localparam int CNT_BITS   = 6;
  localparam int LIDX_BITS  = 4;
  localparam int TOP_BITS   = 8;

  typedef struct packed {
    logic                 vld;
    logic [WORD_BITS-1:0] word;
    logic                 last;
    logic [TOP_BITS-1:0]  top;
  } out_beat_t;

endpackage

// File: rtl/csidh_rr2fr_if.sv
// csidh_rr2fr_if: limb input and word output handshakes.
// slave = converter side, master = producer/consumer side.
interface csidh_rr2fr_if;
  import csidh_rr_pkg::*;

  logic                 in_valid;
  logic [WORD_BITS-1:0] in_limb;
  logic                 in_ready;
  logic                 out_valid;
  logic [WORD_BITS-1:0] out_word;
  logic                 out_last;
  logic [TOP_BITS-1:0]  out_top;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_limb, out_ready,
    output in_ready, out_valid, out_word,
    output out_last, out_top
  );

  modport master (
    output in_valid, in_limb, out_ready,
    input  in_ready, out_valid, out_word,
    input  out_last, out_top
  );

endinterface

// File: rtl/csidh_rr_carry.sv
// csidh_rr_carry: adds the running carry to a limb, splits the sum
// into a 57-bit digit and the next 7-bit signed carry.
module csidh_rr_carry
  import csidh_rr_pkg::*;
(
  input  logic [WORD_BITS-1:0]  limb_i,
  input  logic [CARRY_BITS-1:0] c_i,
  output logic [LIMB_BITS-1:0]  digit_o,
  output logic [CARRY_BITS-1:0] c_o
);

  logic [WORD_BITS-1:0] t;

  assign t = limb_i
           + {{(WORD_BITS-CARRY_BITS){c_i[CARRY_BITS-1]}}, c_i};

  assign digit_o = t[LIMB_BITS-1:0];
  // Top 7 bits of t are exactly t >>> 57 in 7-bit signed form.
  assign c_o     = t[WORD_BITS-1:LIMB_BITS];

endmodule

// File: rtl/csidh_rr2fr.sv
// csidh_rr2fr: converts 9 signed radix-2^57 limbs into 8 packed
// 64-bit words (LS first) plus the signed residue above bit 511.
// Ports: clk, rst (sync, high), clr (sync abort), bus (slave).
module csidh_rr2fr
  import csidh_rr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  csidh_rr2fr_if.slave   bus
);

  logic [CARRY_BITS-1:0] c_q, c_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [LIDX_BITS-1:0]  lidx_q, lidx_d;
  logic [BUF_BITS-1:0]   buf_q, buf_d;
  out_beat_t             ob_q, ob_d;

  logic                  in_ready;
  logic                  acc;
  logic                  emit;
  logic                  last;
  logic                  retire;
  logic [LIMB_BITS-1:0]  digit;
  logic [CARRY_BITS-1:0] c_next;
  logic [BUF_BITS-1:0]   merged;

  csidh_rr_carry u_carry (
    .limb_i  (bus.in_limb),
    .c_i     (c_q),
    .digit_o (digit),
    .c_o     (c_next)
  );

  assign in_ready = !ob_q.vld || bus.out_ready;
  assign acc      = bus.in_valid && in_ready && !clr;
  assign retire   = ob_q.vld && bus.out_ready;
  assign last     = (lidx_q == LIDX_BITS'(NLIMBS-1));
  // cnt + 57 >= 64 reduces to cnt >= 7.
  assign emit     = (cnt_q >= CNT_BITS'(WORD_BITS-LIMB_BITS));
  assign merged   = buf_q | (BUF_BITS'(digit) << cnt_q);

  always_comb begin
    c_d    = c_q;
    cnt_d  = cnt_q;
    lidx_d = lidx_q;
    buf_d  = buf_q;
    ob_d   = ob_q;
    if (retire) begin
      ob_d.vld  = 1'b0;
      ob_d.last = 1'b0;
      ob_d.top  = '0;
    end
    if (acc) begin
      c_d    = c_next;
      lidx_d = lidx_q + 1'b1;
      if (emit) begin
        ob_d.vld  = 1'b1;
        ob_d.word = merged[WORD_BITS-1:0];
        ob_d.last = last;
        ob_d.top  = last ? {c_next, merged[WORD_BITS]} : '0;
        buf_d     = merged >> WORD_BITS;
        cnt_d     = cnt_q - CNT_BITS'(WORD_BITS-LIMB_BITS);
      end else begin
        buf_d = merged;
        cnt_d = cnt_q + CNT_BITS'(LIMB_BITS);
      end
      // Operand boundary: next limb starts a fresh operand.
      if (last) begin
        c_d    = '0;
        cnt_d  = '0;
        lidx_d = '0;
        buf_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      c_q    <= '0;
      cnt_q  <= '0;
      lidx_q <= '0;
      buf_q  <= '0;
      ob_q   <= '0;
    end else begin
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      lidx_q <= lidx_d;
      buf_q  <= buf_d;
      ob_q   <= ob_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ob_q.vld;
  assign bus.out_word  = ob_q.word;
  assign bus.out_last  = ob_q.last;
  assign bus.out_top   = ob_q.top;

endmodule

// File: doc/csidh_rr2fr.md
CSIDH_RR2FR -- requirements
Module: csidh_rr2fr

Interface
REQ-001 Parameters: none; all widths and counts are fixed constants (see Structure).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clr  input  1  synchronous abort; discards the conversion in progress.
REQ-005 in_valid  input  1  a limb is offered on in_limb.
REQ-006 in_limb  input  64  signed reduced-radix limb: radix 2^57 digit plus signed headroom.
REQ-007 in_ready  output  1  the block accepts in_limb this cycle.
REQ-008 out_valid  output  1  out_word holds a full-radix word.
REQ-009 out_word  output  64  packed full-radix word, least-significant word first.
REQ-010 out_last  output  1  qualifies word index 7 of the current operand.
REQ-011 out_top  output  8  signed value above bit 511, i.e. 2*final_carry + leftover_bit; valid with out_last.
REQ-012 out_ready  input  1  the consumer takes out_word this cycle.

Function
REQ-013 An operand is 9 limbs, limb 0 first; value = sum(limb_i * 2^(57*i)), signed.
REQ-014 A limb is accepted iff in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-015 Carry register c: 7-bit signed, 0 at operand start.
REQ-016 On accepting a limb: t = in_limb + sext64(c), modulo 2^64; digit = t[56:0]; c_next = t >>> 57 (arithmetic shift, range -64..63).
REQ-017 Digits append at bit position cnt of a 120-bit bit buffer; cnt is held in 0..63 between limbs.
REQ-018 If cnt+57 >= 64, buffer bits [63:0] load into out_word, out_valid sets next cycle, buffer shifts right by 64, cnt = cnt+57-64; otherwise cnt = cnt+57.
REQ-019 Consequence: limb 0 emits no word, and limbs 1..8 each emit exactly one word with 1-cycle latency; cnt = 1 after limb 8.
REQ-020 With limb 8's word: out_last=1, out_top = {c_next, buffer bit 0} as an 8-bit signed value; out_top = 0 and out_last = 0 otherwise.
REQ-021 out_valid clears when out_ready=1 and no new word loads; a word held under out_valid && !out_ready keeps out_word, out_last and out_top stable.
REQ-022 Limb counter 0..8; after limb 8 it wraps to 0, c and cnt clear, and the buffer zeroes; back-to-back operands need no idle cycle.
REQ-023 Simultaneous out_ready and in accept: the old word retires and the new word loads in the same edge.
REQ-024 clr: same effect as rst on all state and outputs; clr together with in_valid accepts nothing; a pending out_word is dropped.

Reset
REQ-025 On rst: out_valid=0, out_word=0, out_last=0, out_top=0, c=0, cnt=0, limb counter=0, buffer=0; in_ready=1 in the cycle after reset.
REQ-026 rst has priority over clr and over any handshake in the same cycle.

Structure
REQ-027 Package csidh_rr_pkg holds LIMB_BITS=57, NLIMBS=9, NWORDS=8, CARRY_BITS=7, BUF_BITS=120.
REQ-028 One sub-module, csidh_rr_carry: combinational t/digit/c_next computation per REQ-016; buffer, counters and handshake stay in the top.

Verification
REQ-029 All 9 limbs = 2^57-1, out_ready=1 -> 8 words 0xFFFFFFFFFFFFFFFF, out_top=0x01 on word 7.
REQ-030 limb0 = 2^57, others 0 -> word0 = 0x0200000000000000, words 1-7 = 0, out_top=0x00.
REQ-031 limb0 = 0xFFFFFFFFFFFFFFFF (-1), others 0 -> all 8 words 0xFFFFFFFFFFFFFFFF, out_top=0xFF (-1).
REQ-032 Test 029 with out_ready=0 for 3 cycles after word 2 -> in_ready=0 during the stall, word 2 is held stable, no limb is lost, and the output sequence is identical.
REQ-033 clr after limb 4, then a fresh test-030 operand -> no stale word is emitted, and the test-030 output is produced exactly.
REQ-034 rst asserted mid-operand -> outputs match REQ-025 next cycle, and the following operand converts correctly.
